// File: rtl/dt_walker_pkg.sv
// dt_pkg: shared definitions for the decision-tree walker.
//   - node word field bit positions
//   - field codes for leaf marker, sequential left child, leaf verdicts
//   - walker FSM state encoding
package dt_pkg;

    // Node memory word width.
    localparam int unsigned NODE_W = 32;

    // Node word layout: {feature[31:28], threshold[27:12], left[11:8], right[7:0]}
    localparam int unsigned FEAT_HI  = 31;
    localparam int unsigned FEAT_LO  = 28;
    localparam int unsigned THR_HI   = 27;
    localparam int unsigned THR_LO   = 12;
    localparam int unsigned LEFT_HI  = 11;
    localparam int unsigned LEFT_LO  = 8;
    localparam int unsigned RIGHT_HI = 7;
    localparam int unsigned RIGHT_LO = 0;

    // Feature index 0xF marks a leaf; on a leaf the left field carries the verdict.
    localparam logic [3:0] LEAF_FEAT   = 4'hF;
    localparam logic [3:0] LEFT_NEXT   = 4'h0;
    localparam logic [3:0] LEAF_ACCEPT = 4'hF;
    localparam logic [3:0] LEAF_DROP   = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dt_walker_if.sv
// dt_walker_if: bundles the three walker-facing channels.
//   in_*      feature-vector handshake from the extractor (valid/ready)
//   mem_*     node memory read port (registered ROM, 1-cycle latency)
//   out_*     verdict handshake towards the filter action stage (valid/ready)
// Handshake rule for both in_* and out_*: a transfer happens on a rising
// clock edge where valid and ready are both 1; valid, once raised, holds its
// payload stable until that edge.
// modport master: the walker; modport slave: its environment.
interface dt_walker_if
    import dt_pkg::*;
#(
    parameter int unsigned NUM_FEAT = 16,
    parameter int unsigned FEAT_W   = 16,
    parameter int unsigned ADDR_W   = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_FEAT*FEAT_W-1:0] in_features;
    logic [ADDR_W-1:0]          mem_addr;
    logic [NODE_W-1:0]          mem_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_accept;
    logic                       out_error;
    logic [5:0]                 out_depth;

    modport master (
        input  in_valid, in_features, mem_data, out_ready,
        output in_ready, mem_addr, out_valid, out_accept, out_error, out_depth
    );

    modport slave (
        output in_valid, in_features, mem_data, out_ready,
        input  in_ready, mem_addr, out_valid, out_accept, out_error, out_depth
    );
endinterface

// File: rtl/dt_walker_node_decode.sv
// dt_node_decode: combinational decode of one node word.
// Ports:
//   node_i        node word read for cur_node_i
//   cur_node_i    index of the node being evaluated
//   features_i    latched feature vector, feature i at [i*FEAT_W +: FEAT_W]
//   is_leaf_o     feature field is the leaf marker
//   leaf_accept_o leaf with ACCEPT verdict
//   leaf_bad_o    leaf with an unknown verdict code
//   next_idx_o    child selected by the branch rule (meaningless on a leaf)
module dt_node_decode
    import dt_pkg::*;
#(
    parameter int unsigned NUM_FEAT = 16,
    parameter int unsigned FEAT_W   = 16,
    parameter int unsigned ADDR_W   = 8
)(
    input  logic [NODE_W-1:0]          node_i,
    input  logic [ADDR_W-1:0]          cur_node_i,
    input  logic [NUM_FEAT*FEAT_W-1:0] features_i,
    output logic                       is_leaf_o,
    output logic                       leaf_accept_o,
    output logic                       leaf_bad_o,
    output logic [ADDR_W-1:0]          next_idx_o
);
    logic [3:0]        feat_idx;
    logic [FEAT_W-1:0] thr;
    logic [3:0]        left_code;
    logic [7:0]        right_idx;
    logic [FEAT_W-1:0] feat_val;
    logic [ADDR_W-1:0] left_idx;
    logic              go_left;

    assign feat_idx  = node_i[FEAT_HI:FEAT_LO];
    assign thr       = FEAT_W'(node_i[THR_HI:THR_LO]);
    assign left_code = node_i[LEFT_HI:LEFT_LO];
    assign right_idx = node_i[RIGHT_HI:RIGHT_LO];

    // Explicit mux keeps the feature select in range for any NUM_FEAT.
    always_comb begin
        feat_val = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            if (feat_idx == 4'(i)) begin
                feat_val = features_i[i*FEAT_W +: FEAT_W];
            end
        end
    end

    // Ties go left.
    assign go_left = (feat_val <= thr);

    // Left code 0 means "next node in memory"; any other code is an absolute index.
    assign left_idx = (left_code == LEFT_NEXT) ? (cur_node_i + ADDR_W'(1))
                                               : ADDR_W'(left_code);

    assign next_idx_o    = go_left ? left_idx : ADDR_W'(right_idx);
    assign is_leaf_o     = (feat_idx == LEAF_FEAT);
    assign leaf_accept_o = is_leaf_o && (left_code == LEAF_ACCEPT);
    assign leaf_bad_o    = is_leaf_o && (left_code != LEAF_ACCEPT) && (left_code != LEAF_DROP);

endmodule

// File: rtl/dt_walker.sv
// dt_walker: decision-tree traversal engine.
// Accepts one feature vector, walks the node memory from ROOT until a leaf,
// and returns an ACCEPT/DROP verdict with the number of internal nodes visited.
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   bus          dt_walker_if.master (feature input, node memory port, verdict output)
//   dbg_state_o  current FSM state
// Each internal node costs two cycles: WAIT (memory registers mem_addr) and
// EVAL (node word is present on mem_data). One walk at a time, no overlap.
module dt_walker
    import dt_pkg::*;
#(
    parameter int unsigned NUM_FEAT  = 16,
    parameter int unsigned FEAT_W    = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_NODES = 73,
    parameter int unsigned ROOT      = 0,
    parameter int unsigned MAX_DEPTH = 32
)(
    input  logic          clk,
    input  logic          rst,
    dt_walker_if.master   bus,
    output state_e        dbg_state_o
);
    localparam int unsigned VEC_W = NUM_FEAT * FEAT_W;
    localparam logic [ADDR_W-1:0] ROOT_L      = ADDR_W'(ROOT);
    localparam logic [ADDR_W:0]   NUM_NODES_L = (ADDR_W+1)'(NUM_NODES);
    localparam logic [5:0]        MAX_DEPTH_L = 6'(MAX_DEPTH);

    state_e            state_q,  state_d;
    logic [ADDR_W-1:0] node_q,   node_d;
    logic [5:0]        depth_q,  depth_d;
    logic [VEC_W-1:0]  feat_q,   feat_d;
    logic              accept_q, accept_d;
    logic              error_q,  error_d;

    logic              is_leaf;
    logic              leaf_accept;
    logic              leaf_bad;
    logic [ADDR_W-1:0] next_idx;

    dt_node_decode #(
        .NUM_FEAT (NUM_FEAT),
        .FEAT_W   (FEAT_W),
        .ADDR_W   (ADDR_W)
    ) u_decode (
        .node_i        (bus.mem_data),
        .cur_node_i    (node_q),
        .features_i    (feat_q),
        .is_leaf_o     (is_leaf),
        .leaf_accept_o (leaf_accept),
        .leaf_bad_o    (leaf_bad),
        .next_idx_o    (next_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            node_q   <= ROOT_L;
            depth_q  <= '0;
            feat_q   <= '0;
            accept_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            node_q   <= node_d;
            depth_q  <= depth_d;
            feat_q   <= feat_d;
            accept_q <= accept_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        node_d   = node_q;
        depth_d  = depth_q;
        feat_d   = feat_q;
        accept_d = accept_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    feat_d   = bus.in_features;
                    node_d   = ROOT_L;
                    depth_d  = '0;
                    accept_d = 1'b0;
                    error_d  = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                state_d = EVAL;
            end
            EVAL: begin
                if (is_leaf) begin
                    accept_d = leaf_accept;
                    error_d  = leaf_bad;
                    state_d  = DONE;
                end else if (depth_q == MAX_DEPTH_L) begin
                    accept_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = DONE;
                end else if ({1'b0, next_idx} >= NUM_NODES_L) begin
                    // Never present an out-of-range index to the memory.
                    accept_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    node_d  = next_idx;
                    depth_d = depth_q + 6'd1;
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    node_d  = ROOT_L;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                node_d  = ROOT_L;
            end
        endcase
    end

    // The current node register doubles as the memory address, so mem_addr
    // only moves on entry to WAIT or on return to IDLE.
    assign bus.mem_addr   = node_q;
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_accept = accept_q;
    assign bus.out_error  = error_q;
    assign bus.out_depth  = depth_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dt_walker.sv
module tb_dt_walker;
    import dt_pkg::*;

    localparam int NF = 16;
    localparam int FW = 16;
    localparam int AW = 8;
    localparam int VW = NF * FW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dt_walker_if #(.NUM_FEAT(NF), .FEAT_W(FW), .ADDR_W(AW)) ifa ();
    dt_walker_if #(.NUM_FEAT(NF), .FEAT_W(FW), .ADDR_W(AW)) ifb ();
    state_e dbg_a;
    state_e dbg_b;

    dt_walker #(.MAX_DEPTH(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master), .dbg_state_o(dbg_a));
    dt_walker #(.MAX_DEPTH(3))  dut_b (.clk(clk), .rst(rst), .bus(ifb.master), .dbg_state_o(dbg_b));

    // ---------------- node memory model (registered ROM) ----------------
    logic [31:0] rom [256];
    logic [31:0] mem_a_q;
    logic [31:0] mem_b_q;
    always @(posedge clk) begin
        mem_a_q <= rom[ifa.mem_addr];
        mem_b_q <= rom[ifb.mem_addr];
    end
    assign ifa.mem_data = mem_a_q;
    assign ifb.mem_data = mem_b_q;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];  // {accept, error, depth[5:0]}

    function automatic logic [31:0] mk(input logic [3:0] f, input logic [15:0] t,
                                       input logic [3:0] l, input logic [7:0] r);
        return {f, t, l, r};
    endfunction

    task automatic load_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'hF000_0000;   // DROP leaf
        rom[0]  = mk(4'd2,  16'd65,   4'h0, 8'd32);
        rom[1]  = mk(4'd6,  16'd1,    4'h0, 8'd63);
        rom[2]  = mk(4'd3,  16'd100,  4'h0, 8'd40);
        rom[3]  = mk(4'd4,  16'd200,  4'h0, 8'd41);
        rom[4]  = mk(4'd5,  16'd300,  4'h0, 8'd42);
        rom[5]  = mk(4'd7,  16'd400,  4'h0, 8'd43);
        rom[6]  = mk(4'd8,  16'd500,  4'h0, 8'd44);
        rom[7]  = mk(4'hF,  16'd0,    4'hF, 8'd0);
        rom[32] = mk(4'hF,  16'd0,    4'hF, 8'd0);
        rom[40] = mk(4'hF,  16'd0,    4'hF, 8'd0);
        rom[42] = mk(4'hF,  16'd0,    4'h5, 8'd0);  // bad verdict code
        rom[43] = mk(4'hF,  16'd0,    4'hF, 8'd0);
        rom[63] = mk(4'd13, 16'd1000, 4'h0, 8'd45);
        rom[64] = mk(4'd9,  16'd10,   4'h0, 8'd46);
        rom[65] = mk(4'd10, 16'd10,   4'h0, 8'd47);
        rom[66] = mk(4'd11, 16'd10,   4'h0, 8'd48);
        rom[67] = mk(4'd0,  16'd5,    4'hC, 8'd72);
        rom[72] = mk(4'hF,  16'd0,    4'hF, 8'd0);
    endtask

    // Reference walk over the bench ROM; returns {accept, error, depth}.
    function automatic logic [7:0] model_walk(input logic [VW-1:0] f, input int max_depth);
        int node = 0;
        int depth = 0;
        logic [31:0] w;
        logic [15:0] fv;
        int nxt;
        for (int step = 0; step < 64; step++) begin
            w = rom[node];
            if (w[31:28] == 4'hF) begin
                return {(w[11:8] == 4'hF), !((w[11:8] == 4'hF) || (w[11:8] == 4'h0)), 6'(depth)};
            end
            if (depth == max_depth) return {1'b0, 1'b1, 6'(depth)};
            fv = f[int'(w[31:28])*16 +: 16];
            if (fv <= w[27:12]) nxt = (w[11:8] == 4'h0) ? node + 1 : int'(w[11:8]);
            else                nxt = int'(w[7:0]);
            if (nxt >= 73) return {1'b0, 1'b1, 6'(depth)};
            node = nxt;
            depth = depth + 1;
        end
        return 8'hFF;
    endfunction

    function automatic logic [VW-1:0] setf(input logic [VW-1:0] v, input int idx, input logic [15:0] val);
        logic [VW-1:0] r = v;
        r[idx*16 +: 16] = val;
        return r;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic drive_in(input bit sel, input logic v, input logic [VW-1:0] f);
        if (sel) begin ifb.in_valid = v; ifb.in_features = f; end
        else     begin ifa.in_valid = v; ifa.in_features = f; end
    endtask

    task automatic set_out_ready(input bit sel, input logic v);
        if (sel) ifb.out_ready = v; else ifa.out_ready = v;
    endtask

    function automatic logic obs_valid(input bit sel);
        return sel ? ifb.out_valid : ifa.out_valid;
    endfunction
    function automatic logic obs_ready(input bit sel);
        return sel ? ifb.in_ready : ifa.in_ready;
    endfunction
    function automatic logic [7:0] obs_verdict(input bit sel);
        return sel ? {ifb.out_accept, ifb.out_error, ifb.out_depth}
                   : {ifa.out_accept, ifa.out_error, ifa.out_depth};
    endfunction
    function automatic logic [AW-1:0] obs_addr(input bit sel);
        return sel ? ifb.mem_addr : ifa.mem_addr;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NF; i++) v[i*16 +: 16] = 16'($urandom_range(0, 1100));
        return v;
    endfunction

    // Hand a vector over; returns at the negedge after handshake edge 0.
    task automatic start_walk(input bit sel, input logic [VW-1:0] f, input logic [7:0] exp, input string name);
        @(negedge clk);
        checks++;
        if (obs_ready(sel) !== 1'b1) begin
            failures++;
            $display("FAIL %s start: in_ready=%b required 1", name, obs_ready(sel));
        end
        drive_in(sel, 1'b1, f);
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        drive_in(sel, 1'b0, rand_vec());  // must not disturb the latched vector
        checks++;
        if (obs_ready(sel) !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: in_ready=%b required 0", name, obs_ready(sel));
        end
    endtask

    logic [AW-1:0] max_addr;

    task automatic wait_verdict(input bit sel, input int exp_edge, input string name, input bit rel);
        int n = 0;
        logic [7:0] exp;
        max_addr = obs_addr(sel);
        while (obs_valid(sel) !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (obs_addr(sel) > max_addr) max_addr = obs_addr(sel);
        end
        if (obs_valid(sel) !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: out_valid=%b required 1 within 200 cycles", name, obs_valid(sel));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        checks++;
        if (n != exp_edge) begin
            failures++;
            $display("FAIL %s latency: out_valid at edge %0d required %0d", name, n, exp_edge);
        end
        exp = exp_q.pop_front();
        checks++;
        if (obs_verdict(sel) !== exp) begin
            failures++;
            $display("FAIL %s verdict: {acc,err,depth}=%h required %h", name, obs_verdict(sel), exp);
        end
        if (rel) begin
            set_out_ready(sel, 1'b1);
            @(posedge clk);
            @(negedge clk);
            set_out_ready(sel, 1'b0);
            checks++;
            if (obs_valid(sel) !== 1'b0 || obs_ready(sel) !== 1'b1 || obs_addr(sel) !== '0) begin
                failures++;
                $display("FAIL %s release: valid=%b ready=%b addr=%h required 0 1 00",
                         name, obs_valid(sel), obs_ready(sel), obs_addr(sel));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_in(0, 1'b0, '0);
        drive_in(1, 1'b0, '0);
        set_out_ready(0, 1'b0);
        set_out_ready(1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || obs_verdict(0) !== 8'h00 ||
            ifa.mem_addr !== 8'h00 || dbg_a !== IDLE) begin
            failures++;
            $display("FAIL reset_a: ready=%b valid=%b verdict=%h addr=%h state=%0d required 1 0 00 00 0",
                     ifa.in_ready, ifa.out_valid, obs_verdict(0), ifa.mem_addr, dbg_a);
        end
        checks++;
        if (ifb.in_ready !== 1'b1 || ifb.out_valid !== 1'b0 || obs_verdict(1) !== 8'h00) begin
            failures++;
            $display("FAIL reset_b: ready=%b valid=%b verdict=%h required 1 0 00",
                     ifb.in_ready, ifb.out_valid, obs_verdict(1));
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        start_walk(0, '0, {1'b1, 1'b0, 6'd7}, "all_zero");
        wait_verdict(0, 16, "all_zero", 1'b1);
    endtask

    task automatic test_drop_path();
        logic [VW-1:0] f = '0;
        f = setf(f, 6, 16'd2);
        f = setf(f, 13, 16'd600);
        f = setf(f, 0, 16'd3);
        start_walk(0, f, {1'b0, 1'b0, 6'd7}, "drop_path");
        wait_verdict(0, 16, "drop_path", 1'b1);
    endtask

    task automatic test_threshold_edge();
        start_walk(0, setf('0, 2, 16'd65), {1'b1, 1'b0, 6'd7}, "thr_equal");
        wait_verdict(0, 16, "thr_equal", 1'b1);
        start_walk(0, setf('0, 2, 16'd66), {1'b1, 1'b0, 6'd1}, "thr_above");
        wait_verdict(0, 4, "thr_above", 1'b1);
    endtask

    task automatic test_bad_leaf();
        // N0 left, N1 left, N2..N3 left, f5 above N4 threshold -> N42 (bad code)
        start_walk(0, setf('0, 5, 16'd301), {1'b0, 1'b1, 6'd5}, "bad_leaf");
        wait_verdict(0, 12, "bad_leaf", 1'b1);
    endtask

    task automatic test_max_depth();
        start_walk(1, '0, {1'b0, 1'b1, 6'd3}, "max_depth");
        wait_verdict(1, 8, "max_depth", 1'b1);
    endtask

    task automatic test_range_fault();
        @(negedge clk);
        rom[0] = mk(4'd2, 16'd65, 4'h0, 8'h50);
        start_walk(0, setf('0, 2, 16'd100), {1'b0, 1'b1, 6'd0}, "range_fault");
        wait_verdict(0, 2, "range_fault", 1'b1);
        checks++;
        if (max_addr > 8'h48) begin
            failures++;
            $display("FAIL range_addr: max mem_addr=%h required <= 48", max_addr);
        end
        rom[0] = mk(4'd2, 16'd65, 4'h0, 8'd32);
    endtask

    task automatic test_backpressure();
        start_walk(0, '0, {1'b1, 1'b0, 6'd7}, "bp");
        wait_verdict(0, 16, "bp", 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_in(0, 1'b1, rand_vec());
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ifa.out_valid !== 1'b1 || obs_verdict(0) !== {1'b1, 1'b0, 6'd7} ||
                ifa.in_ready !== 1'b0 || ifa.mem_addr !== 8'd7 || dbg_a !== DONE) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b verdict=%h ready=%b addr=%h required 1 87 0 07",
                         i, ifa.out_valid, obs_verdict(0), ifa.in_ready, ifa.mem_addr);
            end
        end
        drive_in(0, 1'b0, '0);
        set_out_ready(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_out_ready(0, 1'b0);
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.mem_addr !== 8'd0) begin
            failures++;
            $display("FAIL bp_release: valid=%b ready=%b addr=%h required 0 1 00",
                     ifa.out_valid, ifa.in_ready, ifa.mem_addr);
        end
    endtask

    task automatic test_reset_mid_walk();
        int seen = 0;
        @(negedge clk);
        drive_in(0, 1'b1, '0);
        @(posedge clk);
        @(negedge clk);
        drive_in(0, 1'b0, '0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.mem_addr !== 8'd0 || dbg_a !== IDLE) begin
            failures++;
            $display("FAIL mid_reset: ready=%b valid=%b addr=%h state=%0d required 1 0 00 0",
                     ifa.in_ready, ifa.out_valid, ifa.mem_addr, dbg_a);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifa.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_reset_verdict: out_valid seen %0d cycles required 0", seen);
        end
        test_all_zero();
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] f = '0;
        f = setf(f, 6, 16'd2);
        f = setf(f, 13, 16'd600);
        f = setf(f, 0, 16'd3);
        start_walk(0, f, {1'b0, 1'b0, 6'd7}, "b2b_first");
        wait_verdict(0, 16, "b2b_first", 1'b0);
        set_out_ready(0, 1'b1);
        drive_in(0, 1'b1, '0);
        exp_q.push_back({1'b1, 1'b0, 6'd7});
        @(posedge clk);
        @(negedge clk);
        set_out_ready(0, 1'b0);
        checks++;
        if (ifa.in_ready !== 1'b1 || dbg_a !== IDLE || ifa.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: ready=%b state=%0d valid=%b required 1 0 0",
                     ifa.in_ready, dbg_a, ifa.out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        drive_in(0, 1'b0, rand_vec());
        checks++;
        if (ifa.in_ready !== 1'b0 || dbg_a !== WAIT) begin
            failures++;
            $display("FAIL b2b_accept: ready=%b state=%0d required 0 1", ifa.in_ready, dbg_a);
        end
        wait_verdict(0, 16, "b2b_second", 1'b1);
    endtask

    task automatic test_random();
        logic [VW-1:0] f;
        logic [7:0] exp;
        for (int i = 0; i < 10; i++) begin
            bit sel = (i % 3 == 2);
            f = rand_vec();
            if ($urandom_range(0, 1) == 1) f = setf(f, 2, 16'($urandom_range(0, 65)));
            if ($urandom_range(0, 1) == 1) f = setf(f, 6, 16'($urandom_range(0, 1)));
            exp = model_walk(f, sel ? 3 : 32);
            start_walk(sel, f, exp, "random");
            wait_verdict(sel, 2 * int'(exp[5:0]) + 2, "random", 1'b1);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        load_rom();
        drive_in(0, 1'b0, '0);
        drive_in(1, 1'b0, '0);
        set_out_ready(0, 1'b0);
        set_out_ready(1, 1'b0);
        test_reset();
        test_all_zero();
        test_drop_path();
        test_threshold_edge();
        test_bad_leaf();
        test_max_depth();
        test_range_fault();
        test_backpressure();
        test_reset_mid_walk();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
